// File: rtl/wb_lsu_master_pkg.sv
// wb_lsu_master_pkg
// Shared definitions for the CPU and the load/store unit:
//   lsu_size_e  - access size encoding carried on i_size
//   lsu_state_e - LSU bus FSM states
//   access_ok() - alignment/legality check for a request
package wb_lsu_master_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

  // A request may start a bus cycle only when it is naturally aligned
  // and uses one of the three legal sizes.
  function automatic logic access_ok(input lsu_size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~addr_lo[0];
      SIZE_WORD: return (addr_lo == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_lsu_master_if.sv
// wb_lsu_master_if
// Pipelined Wishbone bus between the LSU master and a slave.
//   cyc, stb, we, addr, wdata, sel : master -> slave
//   ack, stall, rdata              : slave -> master
interface wb_lsu_master_if #(
  parameter int ADDR_WIDTH = 10
);

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            sel;
  logic                  ack;
  logic                  stall;
  logic [31:0]           rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  ack, stall, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output ack, stall, rdata
  );

endinterface

// File: rtl/wb_lsu_master_lsu_align.sv
// wb_lsu_master_lsu_align
// Purely combinational byte-lane logic for the LSU.
//   addr_lo     - byte offset within the word
//   size        - access size
//   is_unsigned - zero-extend (1) or sign-extend (0) loads
//   wdata       - right-aligned store data
//   rdata       - word returned by the slave
//   sel         - byte-lane enables
//   wdata_rep   - store data replicated across all lanes
//   load_data   - selected lane shifted to bit 0 and extended
module wb_lsu_master_lsu_align
  import wb_lsu_master_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    sel       = 4'b0000;
    wdata_rep = wdata;
    case (size)
      SIZE_BYTE: begin
        sel       = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        sel       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      SIZE_WORD: begin
        sel       = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        sel       = 4'b0000;
        wdata_rep = wdata;
      end
    endcase
  end

  // Lane extraction: a half access is always on an even byte, so
  // only addr_lo[1] matters for picking its lane.
  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    load_data = rdata;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'b0, byte_lane}
                                         : {{24{byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_data = is_unsigned ? {16'b0, half_lane}
                                         : {{16{half_lane[15]}}, half_lane};
      default:   load_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// wb_lsu_master
// Load/store unit that turns single CPU accesses into pipelined
// Wishbone cycles, with alignment checking and an ack timeout.
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_req, i_we, i_addr,
//   i_wdata, i_size,
//   i_unsigned              - CPU request (sampled only when idle)
//   o_busy                  - any state other than IDLE
//   o_done, o_err           - one-cycle completion pulse and its error flag
//   o_rdata                 - last load result, held until the next load
//   wb                      - Wishbone master port
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  wb_lsu_master_if.master wb
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  lsu_state_e            state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            sel_q, sel_d;
  lsu_size_e             size_q, size_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  unsigned_q, unsigned_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  lsu_size_e             req_size;
  logic [1:0]            align_addr_lo;
  lsu_size_e             align_size;
  logic [3:0]            align_sel;
  logic [31:0]           align_wdata;
  logic [31:0]           align_load;
  logic [CNT_W-1:0]      cnt_next;
  logic                  unused_addr_hi;

  assign req_size       = lsu_size_e'(i_size);
  assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH];

  // The aligner is shared: while idle it shapes the incoming store,
  // afterwards it extracts the load lane using the latched request.
  assign align_addr_lo = (state_q == ST_IDLE) ? i_addr[1:0] : addr_lo_q;
  assign align_size    = (state_q == ST_IDLE) ? req_size    : size_q;

  wb_lsu_master_lsu_align u_lsu_align (
    .addr_lo     (align_addr_lo),
    .size        (align_size),
    .is_unsigned (unsigned_q),
    .wdata       (i_wdata),
    .rdata       (wb.rdata),
    .sel         (align_sel),
    .wdata_rep   (align_wdata),
    .load_data   (align_load)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    size_d     = size_q;
    addr_lo_d  = addr_lo_q;
    unsigned_d = unsigned_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cnt_next   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          we_d       = i_we;
          size_d     = req_size;
          addr_lo_d  = i_addr[1:0];
          unsigned_d = i_unsigned;
          if (access_ok(req_size, i_addr[1:0])) begin
            state_d = ST_STROBE;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
            sel_d   = align_sel;
            wdata_d = align_wdata;
            cnt_d   = '0;
          end else begin
            // Rejected requests complete immediately without touching the bus.
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      ST_STROBE: begin
        if (!wb.stall) begin
          stb_d = 1'b0;
          if (wb.ack) begin
            state_d = ST_DONE;
            cyc_d   = 1'b0;
            done_d  = 1'b1;
            if (!we_q) rdata_d = align_load;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (wb.ack) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) rdata_d = align_load;
        end else begin
          cnt_d = cnt_next;
          if (cnt_next == CNT_MAX) begin
            state_d = ST_DONE;
            cyc_d   = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      size_q     <= SIZE_BYTE;
      addr_lo_q  <= '0;
      unsigned_q <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      size_q     <= size_d;
      addr_lo_q  <= addr_lo_d;
      unsigned_q <= unsigned_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_rdata  = rdata_q;
  assign wb.cyc   = cyc_q;
  assign wb.stb   = stb_q;
  assign wb.we    = we_q;
  assign wb.addr  = addr_q;
  assign wb.wdata = wdata_q;
  assign wb.sel   = sel_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// tb_wb_lsu_master
// Directed bench for wb_lsu_master with a registered-ack Wishbone
// slave model backed by a small word memory.
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        isUnsigned;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        ackEnable;

  logic [31:0] mem [0:255];

  int checkCount = 0;
  int errorCount = 0;
  int latency;

  wb_lsu_master_if #(.ADDR_WIDTH(10)) wb ();

  wb_lsu_master #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(15)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_req      (req),
    .i_we       (we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_size     (size),
    .i_unsigned (isUnsigned),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_rdata    (rdata),
    .wb         (wb)
  );

  always #5 clk = ~clk;

  // Slave: accepts a strobe when not stalled and answers one cycle later.
  always @(posedge clk) begin
    wb.ack <= 1'b0;
    if (wb.cyc && wb.stb && !wb.stall && ackEnable) begin
      wb.ack   <= 1'b1;
      wb.rdata <= mem[wb.addr[9:2]];
      if (wb.we) begin
        for (int b = 0; b < 4; b++) begin
          if (wb.sel[b]) mem[wb.addr[9:2]][8*b +: 8] <= wb.wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Presents one request on the falling edge and returns just after
  // the rising edge that accepts it.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] s, input logic u);
    @(negedge clk);
    we = w; addr = a; wdata = d; size = s; isUnsigned = u; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles, output int cycles);
    cycles = 0;
    while (!done && cycles < maxCycles) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic stepIdle(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_clr"}, done, 1'b0);
    checkOutput({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    rstN = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    size = 2'd0; isUnsigned = 1'b0; ackEnable = 1'b1;
    wb.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_cyc", wb.cyc, 1'b0);
    checkOutput("rst_sel", wb.sel, 4'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Word store then word load
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
    checkOutput("stw_cyc", wb.cyc, 1'b1);
    checkOutput("stw_stb", wb.stb, 1'b1);
    checkOutput("stw_we", wb.we, 1'b1);
    checkOutput("stw_sel", wb.sel, 4'hF);
    checkOutput("stw_data", wb.wdata, 32'hDEADBEEF);
    checkOutput("stw_addr", wb.addr, 10'h010);
    checkOutput("stw_busy", busy, 1'b1);
    waitDone(40, latency);
    checkOutput("stw_lat", latency, 2);
    checkOutput("stw_err", err, 1'b0);
    checkOutput("stw_cyc_end", wb.cyc, 1'b0);
    stepIdle("stw");

    applyStimulus(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    checkOutput("ldw_sel", wb.sel, 4'hF);
    checkOutput("ldw_we", wb.we, 1'b0);
    waitDone(40, latency);
    checkOutput("ldw_lat", latency, 2);
    checkOutput("ldw_rdata", rdata, 32'hDEADBEEF);
    stepIdle("ldw");

    // Byte store, then signed/unsigned byte and half loads
    applyStimulus(1'b1, 32'h13, 32'h00000080, 2'd0, 1'b0);
    checkOutput("stb_sel", wb.sel, 4'h8);
    checkOutput("stb_data", wb.wdata, 32'h80808080);
    checkOutput("stb_addr", wb.addr, 10'h010);
    waitDone(40, latency);
    checkOutput("stb_lat", latency, 2);
    checkOutput("stb_rdata_kept", rdata, 32'hDEADBEEF);
    stepIdle("stb");

    applyStimulus(1'b0, 32'h13, 32'h0, 2'd0, 1'b0);
    waitDone(40, latency);
    checkOutput("ldb_s", rdata, 32'hFFFFFF80);
    stepIdle("ldb_s");

    applyStimulus(1'b0, 32'h13, 32'h0, 2'd0, 1'b1);
    waitDone(40, latency);
    checkOutput("ldb_u", rdata, 32'h00000080);
    stepIdle("ldb_u");

    applyStimulus(1'b0, 32'h12, 32'h0, 2'd1, 1'b0);
    checkOutput("ldh_hi_sel", wb.sel, 4'hC);
    waitDone(40, latency);
    checkOutput("ldh_hi_s", rdata, 32'hFFFF80AD);
    stepIdle("ldh_hi");

    applyStimulus(1'b0, 32'h10, 32'h0, 2'd1, 1'b1);
    checkOutput("ldh_lo_sel", wb.sel, 4'h3);
    waitDone(40, latency);
    checkOutput("ldh_lo_u", rdata, 32'h0000BEEF);
    stepIdle("ldh_lo");

    // Rejected requests: misaligned half, illegal size, misaligned word
    applyStimulus(1'b0, 32'h11, 32'h0, 2'd1, 1'b0);
    checkOutput("mis_h_done", done, 1'b1);
    checkOutput("mis_h_err", err, 1'b1);
    checkOutput("mis_h_cyc", wb.cyc, 1'b0);
    checkOutput("mis_h_rdata", rdata, 32'h0000BEEF);
    stepIdle("mis_h");

    applyStimulus(1'b0, 32'h10, 32'h0, 2'd3, 1'b0);
    checkOutput("ill_done", done, 1'b1);
    checkOutput("ill_err", err, 1'b1);
    checkOutput("ill_cyc", wb.cyc, 1'b0);
    stepIdle("ill");

    applyStimulus(1'b1, 32'h12, 32'h11111111, 2'd2, 1'b0);
    checkOutput("mis_w_done", done, 1'b1);
    checkOutput("mis_w_err", err, 1'b1);
    checkOutput("mis_w_cyc", wb.cyc, 1'b0);
    stepIdle("mis_w");

    // Stall held for three edges keeps the strobe up for four cycles
    wb.stall = 1'b1;
    applyStimulus(1'b1, 32'h14, 32'h12345678, 2'd2, 1'b0);
    checkOutput("stall_stb0", wb.stb, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall_stb%0d", i), wb.stb, 1'b1);
      checkOutput($sformatf("stall_addr%0d", i), wb.addr, 10'h014);
      checkOutput($sformatf("stall_sel%0d", i), wb.sel, 4'hF);
    end
    wb.stall = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("stall_stb_drop", wb.stb, 1'b0);
    checkOutput("stall_cyc_hold", wb.cyc, 1'b1);
    waitDone(40, latency);
    checkOutput("stall_lat", latency, 1);
    checkOutput("stall_err", err, 1'b0);
    stepIdle("stall");

    applyStimulus(1'b0, 32'h14, 32'h0, 2'd2, 1'b0);
    waitDone(40, latency);
    checkOutput("stall_ld", rdata, 32'h12345678);
    stepIdle("stall_ld");

    // Slave never answers: timeout after the full wait budget
    ackEnable = 1'b0;
    applyStimulus(1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
    waitDone(60, latency);
    checkOutput("to_lat", latency, 16);
    checkOutput("to_err", err, 1'b1);
    checkOutput("to_cyc", wb.cyc, 1'b0);
    checkOutput("to_rdata", rdata, 32'h12345678);
    stepIdle("to");

    // Asynchronous reset in the middle of a wait
    applyStimulus(1'b1, 32'h24, 32'hCAFEF00D, 2'd2, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("arst_pre_cyc", wb.cyc, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_cyc", wb.cyc, 1'b0);
    checkOutput("arst_stb", wb.stb, 1'b0);
    checkOutput("arst_busy", busy, 1'b0);
    checkOutput("arst_done", done, 1'b0);
    checkOutput("arst_rdata", rdata, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("arst_hold_done%0d", i), done, 1'b0);
    end

    // First request is taken on the first edge after reset release
    @(negedge clk);
    ackEnable = 1'b1;
    rstN = 1'b1;
    we = 1'b0; addr = 32'h10; wdata = '0; size = 2'd2; isUnsigned = 1'b0; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    checkOutput("post_rst_cyc", wb.cyc, 1'b1);
    waitDone(40, latency);
    checkOutput("post_rst_lat", latency, 2);
    checkOutput("post_rst_rdata", rdata, 32'h80ADBEEF);
    stepIdle("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wb_lsu_master.md
WB_LSU_MASTER -- requirements
Module: wb_lsu_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, byte-address width driven onto the Wishbone bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 15, max cycles waiting for i_wb_ack before bus error.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_req  in  1  CPU access request; sampled only in IDLE.
REQ-006 i_we  in  1  1 = store, 0 = load.
REQ-007 i_addr  in  32  CPU byte address.
REQ-008 i_wdata  in  32  store data, right-aligned.
REQ-009 i_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 i_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
REQ-011 o_busy  out  1  high whenever state is not IDLE.
REQ-012 o_done  out  1  one-cycle completion pulse.
REQ-013 o_err  out  1  valid with o_done; misaligned, illegal size or timeout.
REQ-014 o_rdata  out  32  extended load result, held until next o_done.
REQ-015 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls, registered.
REQ-016 o_wb_addr  out  ADDR_WIDTH  i_addr[ADDR_WIDTH-1:2] with bits [1:0] forced to 0.
REQ-017 o_wb_data  out  32  lane-replicated store data.
REQ-018 o_wb_sel  out  4  byte-lane enables.
REQ-019 i_wb_ack, i_wb_stall  in  1 each  slave acknowledge and stall.
REQ-020 i_wb_data  in  32  slave read word.

Function
REQ-021 FSM states SHALL be IDLE, STROBE, WAIT, DONE.
REQ-022 IDLE + i_req: request fields SHALL be latched; aligned legal request -> STROBE; misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 3 -> DONE with o_err=1, no bus cycle.
REQ-023 STROBE: cyc=stb=1; i_wb_stall=1 holds STROBE; i_wb_stall=0 -> WAIT (stb=0, cyc=1); i_wb_ack seen in STROBE with stall=0 -> DONE directly.
REQ-024 WAIT: cyc=1, stb=0; i_wb_ack=1 -> DONE; timeout counter reaching TIMEOUT_CYCLES -> DONE with o_err=1.
REQ-025 i_wb_ack SHALL be ignored in IDLE and DONE.
REQ-026 DONE: cyc=stb=0, o_done=1 for exactly one cycle, then IDLE; i_req in DONE ignored.
REQ-027 Sel: byte -> 4'b0001 << addr[1:0]; half -> 4'b0011 (addr[1]=0) or 4'b1100; word -> 4'b1111.
REQ-028 Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-029 Load: lane selected by addr[1:0], shifted to bit 0, extended to 32 bits per i_unsigned; captured into o_rdata on the ack edge; stores and errors leave o_rdata unchanged.
REQ-030 With a zero-stall, one-cycle-registered-ack slave: accept at edge 0, stb high cycle 1, ack cycle 2, o_done high cycle 3.
REQ-031 Timeout counter SHALL clear on entry to STROBE and saturate, never wrap.

Reset
REQ-032 i_rst_n low SHALL immediately force IDLE and all outputs to 0, including mid-transaction (cyc dropped asynchronously, no o_done).
REQ-033 First request SHALL be accepted on the first rising edge after i_rst_n deasserts.

Structure
REQ-034 Size encodings and FSM state constants SHALL live in a shared defines file used by CPU and LSU.
REQ-035 Lane-select, replication and load extraction SHALL be a combinational sub-module lsu_align.

Verification
REQ-036 Word store 0xDEADBEEF addr 0x10, then word load addr 0x10 -> sel 4'b1111, o_rdata=0xDEADBEEF, o_done 3 cycles after accept.
REQ-037 Byte store 0x80 addr 0x13, signed byte load addr 0x13 -> sel 4'b1000, wb_data 0x80808080, o_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-038 Half load addr 0x11 -> no cyc asserted, o_done+o_err one cycle after accept.
REQ-039 Slave never acks -> cyc held TIMEOUT_CYCLES cycles in WAIT, then o_done+o_err, cyc=0.
REQ-040 i_wb_stall high 3 cycles -> stb held 4 cycles, address/sel stable; i_rst_n pulsed low in WAIT -> cyc=0 same cycle, no o_done.
